// File: rtl/pulse_train_gen.sv
// Multi-channel phased pulse generator driven by one shared period counter.
// Periodic or one-shot runs with start/stop control, busy/done status and registered outputs.
module pulse_train_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      trigger,
    input  logic                      mode,
    input  logic [CNT_W-1:0]          period,
    input  logic [CNT_W-1:0]          width,
    input  logic [CHANNELS*CNT_W-1:0] phase,
    output logic [CHANNELS-1:0]       pulse,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count
);

    localparam int unsigned PH_W = CHANNELS * CNT_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                state_q,  state_d;
    logic                  mode_q,   mode_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [CNT_W-1:0]      width_q,  width_d;
    logic [PH_W-1:0]       phase_q,  phase_d;
    logic                  stop_q,   stop_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [CHANNELS-1:0]   pulse_q,  pulse_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic                  last_c;

    // Window test on CNT_W+1 bits: (k - ph) mod per < wid, with k < per guaranteed.
    function automatic logic in_window(input logic [CNT_W-1:0] k,
                                       input logic [CNT_W-1:0] ph,
                                       input logic [CNT_W-1:0] per,
                                       input logic [CNT_W-1:0] wid);
        logic [CNT_W:0] diff;
        logic           hit;
        diff = '0;
        hit  = 1'b0;
        if (ph < per) begin
            if (k >= ph) begin
                diff = {1'b0, k} - {1'b0, ph};
            end else begin
                diff = {1'b0, k} + {1'b0, per} - {1'b0, ph};
            end
            hit = (diff < {1'b0, wid});
        end
        return hit;
    endfunction

    assign last_c = (count_q == (period_q - CNT_W'(1)));

    // Next-state, config latch and output computation.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        period_d = period_q;
        width_d  = width_q;
        phase_d  = phase_q;
        stop_d   = stop_q;
        count_d  = '0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        pulse_d  = '0;

        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (enable && trigger && (period != '0)) begin
                    state_d  = S_RUN;
                    mode_d   = mode;
                    period_d = period;
                    width_d  = width;
                    phase_d  = phase;
                end
            end
            S_RUN: begin
                if (last_c && (mode_q || stop_q || !enable)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    count_d = last_c ? '0 : (count_q + CNT_W'(1));
                    // A periodic stop request stays latched even if enable returns.
                    if (!mode_q && !enable) begin
                        stop_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        if (busy_d) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pulse_d[i] = in_window(count_d, phase_d[i*CNT_W +: CNT_W], period_d, width_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            period_q <= '0;
            width_q  <= '0;
            phase_q  <= '0;
            stop_q   <= 1'b0;
            count_q  <= '0;
            pulse_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            width_q  <= width_d;
            phase_q  <= phase_d;
            stop_q   <= stop_d;
            count_q  <= count_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomised self-checking bench for pulse_train_gen against a per-cycle arithmetic reference.
module tb_pulse_train_gen;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned VW       = CHANNELS + CNT_W + 2;
    localparam int          MAXC     = 200;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      enable = 1'b0;
    logic                      trigger = 1'b0;
    logic                      mode = 1'b0;
    logic [CNT_W-1:0]          period = '0;
    logic [CNT_W-1:0]          width = '0;
    logic [CHANNELS*CNT_W-1:0] phase = '0;
    logic [CHANNELS-1:0]       pulse;
    logic                      busy;
    logic                      done;
    logic [CNT_W-1:0]          count;

    int n_cmp = 0;
    int n_err = 0;

    // Observed and expected per-cycle vectors {busy, done, count, pulse}.
    logic [VW-1:0] obs  [MAXC];
    logic [VW-1:0] expv [MAXC];

    int cfg_mode;
    int cfg_p;
    int cfg_w;
    int cfg_ph [CHANNELS];

    pulse_train_gen #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigger(trigger), .mode(mode),
        .period(period), .width(width), .phase(phase),
        .pulse(pulse), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [CHANNELS-1:0] model_pulse(input int k);
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ph[i] < cfg_p && ((k - cfg_ph[i] + cfg_p) % cfg_p) < cfg_w) r[i] = 1'b1;
        end
        return r;
    endfunction

    // len = number of RUN cycles, negative when the start must be rejected.
    function automatic void build_expect(input int len, input int n);
        for (int c = 0; c < n; c++) begin
            if (len < 0 || c > len) expv[c] = '0;
            else if (c == len)      expv[c] = {1'b0, 1'b1, CNT_W'(0), CHANNELS'(0)};
            else                    expv[c] = {1'b1, 1'b0, CNT_W'(c % cfg_p), model_pulse(c % cfg_p)};
        end
    endfunction

    function automatic int run_len(input int stop_at);
        if (cfg_p == 0)    return -1;
        if (cfg_mode != 0) return cfg_p;
        return ((stop_at / cfg_p) + 1) * cfg_p;
    endfunction

    task automatic set_cfg(input int m, input int p, input int w,
                           input int p0, input int p1, input int p2, input int p3);
        cfg_mode = m; cfg_p = p; cfg_w = w;
        cfg_ph[0] = p0; cfg_ph[1] = p1; cfg_ph[2] = p2; cfg_ph[3] = p3;
    endtask

    task automatic start_run();
        mode    = cfg_mode[0];
        period  = CNT_W'(cfg_p);
        width   = CNT_W'(cfg_w);
        for (int i = 0; i < CHANNELS; i++) phase[i*CNT_W +: CNT_W] = CNT_W'(cfg_ph[i]);
        enable  = 1'b1;
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    // Records outputs for n cycles; drops enable at stop_at and pulses trigger at t1/t2.
    task automatic capture(input int n, input int stop_at, input int t1, input int t2, input bit chg_cfg);
        for (int c = 0; c < n; c++) begin
            obs[c] = {busy, done, count, pulse};
            if (c == stop_at) begin
                enable = 1'b0;
                if (chg_cfg) begin
                    width  = CNT_W'($urandom);
                    period = CNT_W'($urandom);
                    phase  = (CHANNELS*CNT_W)'({$urandom, $urandom});
                    mode   = ~mode;
                end
            end
            trigger = (c == t1 || c == t2);
            @(posedge clk); #1;
        end
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, count, pulse} !== VW'(0)) begin
            n_err++;
            $display("FAIL reset_async: got %b want 0", {busy, done, count, pulse});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, count, pulse} !== VW'(0)) begin
            n_err++;
            $display("FAIL reset_release: got %b want 0", {busy, done, count, pulse});
        end
    endtask

    task automatic test_basic();
        set_cfg(0, 8, 2, 0, 2, 4, 6);
        start_run();
        capture(36, 27, -1, -1, 1'b0);
        build_expect(run_len(27), 36);
        for (int c = 0; c < 36; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL basic cyc %0d: got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_wrap();
        set_cfg(0, 5, 3, 3, 0, 1, 4);
        start_run();
        capture(18, 12, -1, -1, 1'b0);
        build_expect(run_len(12), 18);
        for (int c = 0; c < 18; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL wrap cyc %0d: got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_one_shot();
        set_cfg(1, 4, 1, 0, 1, 2, 3);
        start_run();
        capture(8, -1, 1, 4, 1'b0);
        build_expect(run_len(-1), 8);
        for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL one_shot cyc %0d: got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_degenerate();
        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       set_cfg(0, 8, 0, 0, 2, 4, 6);
                1:       set_cfg(1, 8, 8, 0, 3, 5, 7);
                2:       set_cfg(0, 8, 3, 1, 2, 9, 5);
                default: set_cfg(0, 0, 2, 0, 0, 0, 0);
            endcase
            start_run();
            capture(20, 10, -1, -1, 1'b0);
            build_expect(run_len(10), 20);
            for (int c = 0; c < 20; c++) begin
                n_cmp++;
                if (obs[c] !== expv[c]) begin
                    n_err++;
                    $display("FAIL degenerate%0d cyc %0d: got %b want %b", s, c, obs[c], expv[c]);
                end
            end
        end
    endtask

    task automatic test_stop_cfg_change();
        set_cfg(0, 8, 2, 0, 2, 4, 6);
        start_run();
        capture(12, 2, -1, -1, 1'b1);
        build_expect(run_len(2), 12);
        for (int c = 0; c < 12; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL stop_cfg cyc %0d: got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        set_cfg(0, 6, 2, 1, 3, 5, 0);
        start_run();
        capture(3, -1, -1, -1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, count, pulse} !== VW'(0)) begin
            n_err++;
            $display("FAIL async_mid_run: got %b want 0", {busy, done, count, pulse});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, count, pulse} !== VW'(0)) begin
            n_err++;
            $display("FAIL async_no_done: got %b want 0", {busy, done, count, pulse});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_run();
        capture(9, 0, -1, -1, 1'b0);
        build_expect(run_len(0), 9);
        for (int c = 0; c < 9; c++) begin
            n_cmp++;
            if (obs[c] !== expv[c]) begin
                n_err++;
                $display("FAIL async_restart cyc %0d: got %b want %b", c, obs[c], expv[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int p, w, s, len, n, tr;
            p = int'($urandom_range(1, 16));
            w = int'($urandom_range(0, p + 2));
            cfg_mode = int'($urandom_range(0, 1));
            cfg_p = p; cfg_w = w;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w < p && $urandom_range(0, 3) == 0) cfg_ph[i] = int'($urandom_range(p, 255));
                else                                   cfg_ph[i] = int'($urandom_range(0, p - 1));
            end
            s   = int'($urandom_range(0, 3 * p));
            len = run_len(s);
            n   = len + 3;
            tr  = int'($urandom_range(1, len));
            start_run();
            capture(n, s, tr, -1, 1'b1);
            build_expect(len, n);
            for (int c = 0; c < n; c++) begin
                n_cmp++;
                if (obs[c] !== expv[c]) begin
                    n_err++;
                    $display("FAIL random%0d cyc %0d: got %b want %b", it, c, obs[c], expv[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_one_shot();
        test_degenerate();
        test_stop_cfg_change();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
